// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, SIZE cycles per division,
// start/done handshake with registered quotient, remainder and divide-by-zero flag.
module restoring_divider #(
   parameter int SIZE = 16
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            iStart,
   input  logic [SIZE-1:0] iA,
   input  logic [SIZE-1:0] iB,
   output logic            oBusy,
   output logic            oDone,
   output logic [SIZE-1:0] oQuotient,
   output logic [SIZE-1:0] oRemainder,
   output logic            oDivByZero
);

   localparam int CNT_W = (SIZE > 2) ? $clog2(SIZE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [SIZE-1:0]   dividend_r, dividend_s;
   logic [SIZE-1:0]   divisor_r, divisor_s;
   // The restored partial remainder is always below the divisor, so SIZE bits hold it
   logic [SIZE-1:0]   rem_r, rem_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              zero_pend_r, zero_pend_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic [SIZE-1:0]   quot_r, quot_s;
   logic [SIZE-1:0]   remd_r, remd_s;
   logic              dbz_r, dbz_s;

   logic [SIZE:0]     rem_shift_s;
   logic [SIZE:0]     trial_s;
   logic              qbit_s;
   logic [SIZE-1:0]   rem_step_s;
   logic [SIZE-1:0]   dividend_step_s;

   // One restoring step: shift, trial subtract, keep or restore
   always_comb begin
      rem_shift_s = {rem_r, dividend_r[SIZE-1]};
      trial_s     = rem_shift_s - {1'b0, divisor_r};
      qbit_s      = ~trial_s[SIZE];
      if (qbit_s) begin
         rem_step_s = trial_s[SIZE-1:0];
      end else begin
         rem_step_s = rem_shift_s[SIZE-1:0];
      end
      dividend_step_s = {dividend_r[SIZE-2:0], qbit_s};
   end

   // Next-state, datapath and output-register logic
   always_comb begin
      state_s     = state_r;
      dividend_s  = dividend_r;
      divisor_s   = divisor_r;
      rem_s       = rem_r;
      cnt_s       = cnt_r;
      zero_pend_s = zero_pend_r;
      busy_s      = 1'b0;
      done_s      = 1'b0;
      quot_s      = quot_r;
      remd_s      = remd_r;
      dbz_s       = dbz_r;
      case (state_r)
         IDLE, DONE: begin
            if (zero_pend_r) begin
               quot_s      = {SIZE{1'b1}};
               remd_s      = dividend_r;
               dbz_s       = 1'b1;
               done_s      = 1'b1;
               zero_pend_s = 1'b0;
               state_s     = DONE;
            end else if (iStart) begin
               dividend_s = iA;
               divisor_s  = iB;
               rem_s      = {SIZE{1'b0}};
               cnt_s      = {CNT_W{1'b0}};
               if (iB != {SIZE{1'b0}}) begin
                  state_s = RUN;
                  busy_s  = 1'b1;
               end else begin
                  state_s     = DONE;
                  zero_pend_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            dividend_s = dividend_step_s;
            rem_s      = rem_step_s;
            if (cnt_r == CNT_LAST) begin
               quot_s  = dividend_step_s;
               remd_s  = rem_step_s;
               dbz_s   = 1'b0;
               done_s  = 1'b1;
               state_s = DONE;
            end else begin
               cnt_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               busy_s = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_r     <= IDLE;
         dividend_r  <= {SIZE{1'b0}};
         divisor_r   <= {SIZE{1'b0}};
         rem_r       <= {SIZE{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         zero_pend_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         quot_r      <= {SIZE{1'b0}};
         remd_r      <= {SIZE{1'b0}};
         dbz_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         dividend_r  <= dividend_s;
         divisor_r   <= divisor_s;
         rem_r       <= rem_s;
         cnt_r       <= cnt_s;
         zero_pend_r <= zero_pend_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         quot_r      <= quot_s;
         remd_r      <= remd_s;
         dbz_r       <= dbz_s;
      end
   end

   assign oBusy      = busy_r;
   assign oDone      = done_r;
   assign oQuotient  = quot_r;
   assign oRemainder = remd_r;
   assign oDivByZero = dbz_r;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed vector table, multi-cycle corner
// sequences and randomised operands checked against plain integer division.
module tb_restoring_divider;

   localparam int SIZE = 16;

   logic            Clock;
   logic            Reset;
   logic            iStart;
   logic [SIZE-1:0] iA;
   logic [SIZE-1:0] iB;
   logic            oBusy;
   logic            oDone;
   logic [SIZE-1:0] oQuotient;
   logic [SIZE-1:0] oRemainder;
   logic            oDivByZero;

   int errors = 0;
   int checks = 0;

   restoring_divider #(.SIZE(SIZE)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .iStart     (iStart),
      .iA         (iA),
      .iB         (iB),
      .oBusy      (oBusy),
      .oDone      (oDone),
      .oQuotient  (oQuotient),
      .oRemainder (oRemainder),
      .oDivByZero (oDivByZero)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [SIZE-1:0] a;
      logic [SIZE-1:0] b;
      logic [SIZE-1:0] q;
      logic [SIZE-1:0] r;
      logic            dbz;
      int              lat;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait (bounded) for oDone at negedges; lat counts edges after the accepting edge
   task automatic wait_done(input int start, output int lat, output int busy_n);
      lat = start;
      busy_n = 0;
      while (!oDone && lat < 60) begin
         if (oBusy) busy_n++;
         @(negedge Clock);
         lat++;
      end
      if (!oDone) begin
         checks++;
         errors++;
         $display("FAIL timeout: no oDone after %0d cycles", lat);
      end
   endtask

   task automatic run_div(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          output int lat, output int busy_n);
      @(negedge Clock);
      iA = a;
      iB = b;
      iStart = 1'b1;
      @(negedge Clock);
      iStart = 1'b0;
      iA = SIZE'($urandom);
      iB = SIZE'($urandom);
      wait_done(0, lat, busy_n);
   endtask

   initial begin
      int lat, busy_n, dc, dp;
      logic [SIZE-1:0] ra, rb, eq, er;
      logic edbz;

      vecs[0] = '{a: 16'd100,   b: 16'd7,      q: 16'd14,     r: 16'd2,    dbz: 1'b0, lat: 16};
      vecs[1] = '{a: 16'hFFFF,  b: 16'd1,      q: 16'hFFFF,   r: 16'd0,    dbz: 1'b0, lat: 16};
      vecs[2] = '{a: 16'd5,     b: 16'd10,     q: 16'd0,      r: 16'd5,    dbz: 1'b0, lat: 16};
      vecs[3] = '{a: 16'hFFFF,  b: 16'hFFFF,   q: 16'd1,      r: 16'd0,    dbz: 1'b0, lat: 16};
      vecs[4] = '{a: 16'd0,     b: 16'd3,      q: 16'd0,      r: 16'd0,    dbz: 1'b0, lat: 16};
      vecs[5] = '{a: 16'd1234,  b: 16'd0,      q: 16'hFFFF,   r: 16'd1234, dbz: 1'b1, lat: 1};
      vecs[6] = '{a: 16'd50,    b: 16'd6,      q: 16'd8,      r: 16'd2,    dbz: 1'b0, lat: 16};

      Reset = 1'b0;
      iStart = 1'b0;
      iA = 16'd0;
      iB = 16'd0;
      repeat (2) @(negedge Clock);
      chk("reset_busy", oBusy, 1'b0);
      chk("reset_done", oDone, 1'b0);
      chk("reset_q", oQuotient, 16'd0);
      chk("reset_r", oRemainder, 16'd0);
      chk("reset_dbz", oDivByZero, 1'b0);
      Reset = 1'b1;

      // Directed table
      for (int i = 0; i < 7; i++) begin
         run_div(vecs[i].a, vecs[i].b, lat, busy_n);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_busycycles", i), busy_n, (vecs[i].b == 16'd0) ? 0 : SIZE);
         chk($sformatf("vec%0d_busy_at_done", i), oBusy, 1'b0);
         chk($sformatf("vec%0d_q", i), oQuotient, vecs[i].q);
         chk($sformatf("vec%0d_r", i), oRemainder, vecs[i].r);
         chk($sformatf("vec%0d_dbz", i), oDivByZero, vecs[i].dbz);
         @(negedge Clock);
         chk($sformatf("vec%0d_done_drop", i), oDone, 1'b0);
         chk($sformatf("vec%0d_q_hold", i), oQuotient, vecs[i].q);
         chk($sformatf("vec%0d_r_hold", i), oRemainder, vecs[i].r);
      end

      // Busy interlock: second request during RUN is ignored
      @(negedge Clock);
      iA = 16'd100;
      iB = 16'd7;
      iStart = 1'b1;
      @(negedge Clock);
      iStart = 1'b0;
      dc = 0;
      dp = -1;
      for (int p = 0; p < 26; p++) begin
         if (oDone) begin
            dc++;
            dp = p;
         end
         if (p == 5) begin
            iStart = 1'b1;
            iA = 16'd9;
            iB = 16'd3;
         end else begin
            iStart = 1'b0;
         end
         @(negedge Clock);
      end
      chk("interlock_done_count", dc, 1);
      chk("interlock_done_cycle", dp, SIZE);
      chk("interlock_q", oQuotient, 16'd14);
      chk("interlock_r", oRemainder, 16'd2);

      // Back-to-back: iStart held, second operands presented in the oDone cycle
      @(negedge Clock);
      iA = 16'd1000;
      iB = 16'd33;
      iStart = 1'b1;
      @(negedge Clock);
      wait_done(0, lat, busy_n);
      chk("b2b1_lat", lat, SIZE);
      chk("b2b1_q", oQuotient, 16'd30);
      chk("b2b1_r", oRemainder, 16'd10);
      iA = 16'd77;
      iB = 16'd7;
      @(negedge Clock);
      iStart = 1'b0;
      chk("b2b_done_drop", oDone, 1'b0);
      chk("b2b_busy_rise", oBusy, 1'b1);
      repeat (8) @(negedge Clock);
      chk("b2b_q_hold", oQuotient, 16'd30);
      chk("b2b_r_hold", oRemainder, 16'd10);
      wait_done(8, lat, busy_n);
      chk("b2b2_lat", lat, SIZE);
      chk("b2b2_q", oQuotient, 16'd11);
      chk("b2b2_r", oRemainder, 16'd0);

      // Reset asserted between edges in the middle of RUN
      @(negedge Clock);
      iA = 16'd100;
      iB = 16'd7;
      iStart = 1'b1;
      @(negedge Clock);
      iStart = 1'b0;
      repeat (8) @(negedge Clock);
      #2 Reset = 1'b0;
      #1;
      chk("midrst_busy", oBusy, 1'b0);
      chk("midrst_done", oDone, 1'b0);
      chk("midrst_q", oQuotient, 16'd0);
      chk("midrst_r", oRemainder, 16'd0);
      chk("midrst_dbz", oDivByZero, 1'b0);
      @(negedge Clock);
      Reset = 1'b1;
      dc = 0;
      for (int p = 0; p < 20; p++) begin
         @(negedge Clock);
         if (oDone) dc++;
      end
      chk("midrst_no_done", dc, 0);
      run_div(16'd50, 16'd6, lat, busy_n);
      chk("postrst_lat", lat, SIZE);
      chk("postrst_q", oQuotient, 16'd8);
      chk("postrst_r", oRemainder, 16'd2);

      // Randomised operands against integer division
      for (int n = 0; n < 2000; n++) begin
         int sel;
         sel = $urandom_range(0, 9);
         ra = SIZE'($urandom);
         if (sel == 0) rb = 16'd0;
         else if (sel == 1) rb = SIZE'($urandom_range(1, 15));
         else rb = SIZE'($urandom);
         if (rb == 16'd0) begin
            eq = 16'hFFFF;
            er = ra;
            edbz = 1'b1;
         end else begin
            eq = ra / rb;
            er = ra % rb;
            edbz = 1'b0;
         end
         run_div(ra, rb, lat, busy_n);
         chk($sformatf("rand%0d_a%0h_b%0h_q", n, ra, rb), oQuotient, eq);
         chk($sformatf("rand%0d_a%0h_b%0h_r", n, ra, rb), oRemainder, er);
         chk($sformatf("rand%0d_dbz", n), oDivByZero, edbz);
         if (rb != 16'd0) begin
            longint lhs;
            lhs = longint'(oQuotient) * longint'(rb) + longint'(oRemainder);
            chk($sformatf("rand%0d_identity", n), (lhs == longint'(ra)) && (oRemainder < rb), 1'b1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
